// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: the machine word (common) and the
// request/data_ok handshake types and constants (pipes).
package common;
    typedef logic [63:0] word_t;
endpackage

package pipes;
    // Access size, encoded as log2 of the byte count.
    typedef enum logic [2:0] {
        MSIZE_1B = 3'd0,
        MSIZE_2B = 3'd1,
        MSIZE_4B = 3'd2,
        MSIZE_8B = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam logic [15:0] MEM_RESP_LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per 'advance' and
// restarts from MEM_RESP_LFSR_SEED on reset; drives the optional extra access delay.
module resp_lfsr
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= MEM_RESP_LFSR_SEED;
        end else if (advance) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign value = r_lfsr;
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a request, waits a fixed latency, then
// reads or byte-strobe-writes a word array. MEM_RESP_RAND_DELAY_EN adds 0..3 cycles of LFSR delay.
module mem_responder
    import common::*;
    import pipes::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  msize_t      req_size,
    input  strobe_t     req_strobe,
    input  word_t       req_data,
    output logic        addr_ok,
    output logic        data_ok,
    output word_t       resp_data,
    output logic        busy
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 4);
    typedef logic [CNT_W-1:0] cnt_t;

    mem_resp_state_t  r_state;
    mem_resp_state_t  w_state_nxt;
    cnt_t             r_cnt;
    cnt_t             w_cnt_nxt;
    cnt_t             w_delay_m1;
    logic [IDX_W-1:0] r_idx;
    strobe_t          r_strobe;
    word_t            r_data;
    word_t            r_mem [MEM_WORDS];

    logic             w_accept;
    logic             w_access;
    logic [IDX_W-1:0] w_acc_idx;
    strobe_t          w_acc_strobe;
    word_t            w_acc_data;
    word_t            w_merged;
    logic             w_unused_in;

    // Size is informational and the address wraps, so these bits are never decoded.
    assign w_unused_in = &{1'b0, req_size, req_addr[2:0], req_addr[63:3+IDX_W]};

`ifdef MEM_RESP_RAND_DELAY_EN
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    resp_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_accept),
        .value   (w_lfsr)
    );

    assign w_delay_m1    = cnt_t'(LATENCY - 1) + cnt_t'(w_lfsr[1:0]);
    assign w_unused_lfsr = &{1'b0, w_lfsr[15:2]};
`else
    assign w_delay_m1 = cnt_t'(LATENCY - 1);
`endif

    // r_cnt counts edges left before the access edge; a zero load means the
    // access happens on the acceptance edge itself, so addr_ok and data_ok coincide.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_acc_idx    = r_idx;
        w_acc_strobe = r_strobe;
        w_acc_data   = r_data;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = w_delay_m1;
                    if (w_delay_m1 == '0) begin
                        w_access     = 1'b1;
                        w_acc_idx    = req_addr[3 +: IDX_W];
                        w_acc_strobe = req_strobe;
                        w_acc_data   = req_data;
                        w_state_nxt  = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == cnt_t'(1)) begin
                    w_access    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - cnt_t'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_merged = r_mem[w_acc_idx];
        for (int b = 0; b < 8; b++) begin
            if (w_acc_strobe[b]) begin
                w_merged[8*b +: 8] = w_acc_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_strobe  <= '0;
            r_data    <= '0;
            addr_ok   <= 1'b0;
            data_ok   <= 1'b0;
            resp_data <= '0;
            busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            addr_ok <= w_accept;
            data_ok <= w_access;
            busy    <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_idx    <= req_addr[3 +: IDX_W];
                r_strobe <= req_strobe;
                r_data   <= req_data;
            end
            if (w_access) begin
                resp_data <= w_merged;
            end
        end
    end

    // The array is deliberately not reset; reset only blocks a write on its edge.
    always_ff @(posedge clk) begin
        if (w_access && !reset && (w_acc_strobe != '0)) begin
            r_mem[w_acc_idx] <= w_merged;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table vectors, random reads/writes against a word-array
// model, reset during an access, and held-valid back-to-back reads.
module tb_mem_responder;
    import pipes::*;

    localparam int LAT    = 2;
    localparam int WORDS  = 1024;
    localparam int BUDGET = 20;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    msize_t      req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] resp_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] ref_mem [WORDS];
    logic [15:0] ref_lfsr = 16'hACE1;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [12];

    mem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_strobe (req_strobe),
        .req_data   (req_data),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [63:0] addr);
        return int'((addr / 8) % WORDS);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] s,
                                          input logic [63:0] d);
        logic [63:0] mask = '0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) mask = mask | (64'hFF << (8 * b));
        end
        return (old & ~mask) | (d & mask);
    endfunction

    // Expected acceptance-to-data_ok distance for the next accepted request.
    function automatic int ref_latency();
`ifdef MEM_RESP_RAND_DELAY_EN
        int l;
        logic fb;
        l        = LAT + int'(ref_lfsr % 4);
        fb       = ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5];
        ref_lfsr = {fb, ref_lfsr[15:1]};
        return l;
`else
        return LAT;
`endif
    endfunction

    task automatic do_req(input logic [63:0] addr, input logic [7:0] strobe,
                          input logic [63:0] data, output logic [63:0] got,
                          output int lat, output int aok_cyc, output int busy1);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_strobe = strobe;
        req_data   = data;
        req_size   = MSIZE_8B;
        got        = '0;
        lat        = -1;
        aok_cyc    = -1;
        busy1      = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = int'(busy);
            if (addr_ok && aok_cyc < 0) aok_cyc = c;
            if (data_ok) begin
                lat = c;
                got = resp_data;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic apply(input string name, input logic [63:0] addr, input logic [7:0] strobe,
                         input logic [63:0] data, input logic [63:0] exp);
        logic [63:0] got;
        int lat, aok, b1, elat;
        elat = ref_latency();
        do_req(addr, strobe, data, got, lat, aok, b1);
        ref_mem[idx_of(addr)] = merge(ref_mem[idx_of(addr)], strobe, data);
        check({name, " addr_ok cycle"}, 64'(aok), 64'(1));
        check({name, " busy"}, 64'(b1), 64'(1));
        check({name, " latency"}, 64'(lat), 64'(elat));
        check({name, " data"}, got, exp);
    endtask

    initial begin
        logic [63:0] a, d;
        logic [7:0]  s;
        int          ix, k, exp_t, seen;

        vecs[0]  = '{64'h8000_0008, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        vecs[1]  = '{64'h8000_0008, 8'h00, 64'h0,                   64'hDEAD_BEEF_0123_4567};
        vecs[2]  = '{64'h8000_0008, 8'h0F, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF_5566_7788};
        vecs[3]  = '{64'h0000_0008, 8'h00, 64'h0,                   64'hDEAD_BEEF_5566_7788};
        vecs[4]  = '{64'h0000_2000, 8'hFF, 64'h5A,                  64'h5A};
        vecs[5]  = '{64'h0000_0000, 8'h00, 64'h0,                   64'h5A};
        vecs[6]  = '{64'h0000_0010, 8'hFF, 64'h0,                   64'h0};
        vecs[7]  = '{64'h0000_0017, 8'h80, 64'hEE00_0000_0000_0000, 64'hEE00_0000_0000_0000};
        vecs[8]  = '{64'h0000_0010, 8'h00, 64'h0,                   64'hEE00_0000_0000_0000};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708};
        vecs[10] = '{64'h0000_FFF8, 8'h3C, 64'hFFFF_AAAA_BBBB_FFFF, 64'h0102_AAAA_BBBB_0708};
        vecs[11] = '{64'h0000_1FF8, 8'h00, 64'h0,                   64'h0102_AAAA_BBBB_0708};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = MSIZE_8B;
        req_strobe = '0;
        req_data   = '0;
        repeat (3) @(negedge clk);
        check("reset addr_ok", 64'(addr_ok), 64'(0));
        check("reset data_ok", 64'(data_ok), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset resp_data", resp_data, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].addr, vecs[i].strobe, vecs[i].data, vecs[i].exp);
        end

        for (int i = 0; i < 8; i++) begin
            d = {$urandom(), $urandom()};
            apply($sformatf("fill%0d", i), 64'(i * 8), 8'hFF, d, d);
        end
        for (int i = 0; i < 40; i++) begin
            ix = $urandom_range(0, 7);
            a  = {$urandom(), $urandom()};
            a[12:3] = 10'(ix);
            s  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom());
            d  = {$urandom(), $urandom()};
            apply($sformatf("rand%0d", i), a, s, d, merge(ref_mem[ix], s, d));
        end

        // Reset in the middle of the wait: the write must be abandoned.
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 64'h8;
        req_strobe = 8'hFF;
        req_data   = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'(0));
        check("abort addr_ok", 64'(addr_ok), 64'(0));
        check("abort data_ok", 64'(data_ok), 64'(0));
        req_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        ref_lfsr = 16'hACE1;
        seen     = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_ok) seen = 1;
        end
        check("abort no data_ok", 64'(seen), 64'(0));
        check("abort resp_data", resp_data, 64'h0);
        apply("after abort", 64'h8, 8'h00, 64'h0, ref_mem[1]);

        // Held-valid back-to-back reads of words 0..3.
        @(negedge clk);
        k          = 0;
        req_valid  = 1'b1;
        req_addr   = 64'h0;
        req_strobe = 8'h00;
        exp_t      = ref_latency();
        for (int c = 1; c <= BUDGET * 5 && k < 4; c++) begin
            @(negedge clk);
            if (data_ok) begin
                check($sformatf("b2b%0d cycle", k), 64'(c), 64'(exp_t));
                check($sformatf("b2b%0d data", k), resp_data, ref_mem[k]);
                k++;
                if (k < 4) begin
                    req_addr = 64'(k * 8);
                    exp_t    = c + 1 + ref_latency();
                end
            end
        end
        req_valid = 1'b0;
        check("b2b completions", 64'(k), 64'(4));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
